// File: rtl/alu_accumulator_param.sv
// Accumulator ALU: combines Data with the low half of its own 2*WIDTH-bit accumulator.
// Single-cycle ops commit on the accept edge; MUL runs a WIDTH-cycle shift-add sequence.
module alu_accumulator_param #(
   parameter int WIDTH = 4
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic [WIDTH-1:0]   Data,
   input  logic [2:0]         Function,
   input  logic               Valid_in,
   output logic               Ready,
   output logic               Busy,
   output logic               Done,
   output logic [2*WIDTH-1:0] ALUout
);

   localparam int AW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_MUL  = 1'b1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_ORR = 3'b010;
   localparam logic [2:0] OP_ANR = 3'b011;
   localparam logic [2:0] OP_SXT = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;

   // Shift amounts at or above the accumulator width flush the result to zero
   localparam logic [WIDTH:0] SH_LIMIT = (WIDTH + 1)'(AW);

   logic [0:0]       r_state;
   logic [AW-1:0]    r_acc;
   logic [AW-1:0]    r_mcand;
   logic [AW-1:0]    r_prod;
   logic [WIDTH-1:0] r_mplier;
   logic [CW-1:0]    r_cnt;
   logic             r_done;

   logic [AW-1:0]    w_a;
   logic [AW-1:0]    w_b;
   logic [AW-1:0]    w_result;
   logic [AW-1:0]    w_prod_next;

   assign w_a = {{WIDTH{1'b0}}, Data};
   assign w_b = {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]};

   always_comb begin
      w_result = r_acc;
      case (Function)
         OP_ADD:  w_result = w_a + w_b;
         OP_SUB:  w_result = w_a - w_b;
         OP_ORR:  w_result = {{(AW-1){1'b0}}, (|Data) | (|r_acc[WIDTH-1:0])};
         OP_ANR:  w_result = {{(AW-1){1'b0}}, (&Data) & (&r_acc[WIDTH-1:0])};
         OP_SXT:  w_result = {{WIDTH{Data[WIDTH-1]}}, Data};
         OP_SHL:  w_result = ({1'b0, Data} >= SH_LIMIT) ? '0 : (w_b << Data);
         default: w_result = r_acc;
      endcase
   end

   // One multiplier bit per cycle, LSB first; multiplicand shifts left alongside
   assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_prod   <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (Valid_in) begin
                  if (Function == OP_MUL) begin
                     r_mcand  <= w_a;
                     r_mplier <= r_acc[WIDTH-1:0];
                     r_prod   <= '0;
                     r_cnt    <= '0;
                     r_state  <= S_MUL;
                  end else begin
                     r_acc  <= w_result;
                     r_done <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               r_prod   <= w_prod_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_acc   <= w_prod_next;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign Ready  = (r_state == S_IDLE);
   assign Busy   = (r_state == S_MUL);
   assign Done   = r_done;
   assign ALUout = r_acc;

endmodule

// File: tb/tb_alu_accumulator_param.sv
// Bench for alu_accumulator_param at WIDTH=4 and WIDTH=8 against an arithmetic reference model.
module tb_alu_accumulator_param;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst4 = 1'b1, vin4 = 1'b0, rdy4, busy4, done4;
   logic [3:0]  data4 = '0;
   logic [2:0]  fn4 = '0;
   logic [7:0]  out4;

   logic        rst8 = 1'b1, vin8 = 1'b0, rdy8, busy8, done8;
   logic [7:0]  data8 = '0;
   logic [2:0]  fn8 = '0;
   logic [15:0] out8;

   int n_checks = 0;
   int n_fail   = 0;
   longint unsigned m4 = 0, m8 = 0;

   alu_accumulator_param #(.WIDTH(4)) u_dut4 (
      .Clock(clk), .Reset(rst4), .Data(data4), .Function(fn4), .Valid_in(vin4),
      .Ready(rdy4), .Busy(busy4), .Done(done4), .ALUout(out4)
   );

   alu_accumulator_param #(.WIDTH(8)) u_dut8 (
      .Clock(clk), .Reset(rst8), .Data(data8), .Function(fn8), .Valid_in(vin8),
      .Ready(rdy8), .Busy(busy8), .Done(done8), .ALUout(out8)
   );

   // Reference: new accumulator value after one operation, modulo 2^(2w)
   function automatic longint unsigned model(input int w, input logic [2:0] op,
                                             input logic [15:0] a_in, input longint unsigned acc);
      longint unsigned mask2, maskw, a, b, r;
      mask2 = (64'd1 << (2 * w)) - 64'd1;
      maskw = (64'd1 << w) - 64'd1;
      a = 64'(a_in) & maskw;
      b = acc & maskw;
      case (op)
         3'd0: r = a + b;
         3'd1: r = a - b;
         3'd2: r = (a != 0 || b != 0) ? 64'd1 : 64'd0;
         3'd3: r = (a == maskw && b == maskw) ? 64'd1 : 64'd0;
         3'd4: r = (((a >> (w - 1)) & 64'd1) != 0) ? (a | (mask2 & ~maskw)) : a;
         3'd5: r = (a >= 64'(2 * w)) ? 64'd0 : (b << a);
         3'd6: r = a * b;
         default: r = acc;
      endcase
      return r & mask2;
   endfunction

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      tick;
      rst4 = 1'b0; rst8 = 1'b0;
      vin4 = 1'b1; fn4 = 3'd0; data4 = 4'h9;
      tick;
      rst4 = 1'b1; rst8 = 1'b1;
      tick;
      tick;
      rst4 = 1'b0; rst8 = 1'b0; vin4 = 1'b0;
      m4 = 0; m8 = 0;
      n_checks++; if (out4 !== 8'h00) begin n_fail++; $display("FAIL reset_out4: got %h want 00", out4); end
      n_checks++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL reset_ready4: got %b want 1", rdy4); end
      n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy4: got %b want 0", busy4); end
      n_checks++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done4: got %b want 0", done4); end
      n_checks++; if (out8 !== 16'h0000 || rdy8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
         n_fail++; $display("FAIL reset_dut8: got out=%h rdy=%b busy=%b done=%b want 0000/1/0/0", out8, rdy8, busy8, done8);
      end
      tick;
      n_checks++; if (done4 !== 1'b0 || out4 !== 8'h00) begin
         n_fail++; $display("FAIL reset_idle4: got done=%b out=%h want 0/00", done4, out4);
      end
   endtask

   task automatic test_single_ops;
      logic [2:0] ops [13] = '{3'd0, 3'd0, 3'd1, 3'd4, 3'd5, 3'd5, 3'd4, 3'd2, 3'd3, 3'd2, 3'd0, 3'd3, 3'd7};
      logic [3:0] dat [13] = '{4'h5, 4'h3, 4'h2, 4'h3, 4'h2, 4'h9, 4'hA, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0};
      for (int i = 0; i < 13; i++) begin
         vin4 = 1'b1; fn4 = ops[i]; data4 = dat[i];
         m4 = model(4, fn4, 16'(data4), m4);
         tick;
         vin4 = 1'b0;
         n_checks++; if (out4 !== 8'(m4) || done4 !== 1'b1) begin
            n_fail++; $display("FAIL single_op%0d fn=%0d: got out=%h done=%b want %h/1", i, ops[i], out4, done4, 8'(m4));
         end
         tick;
         n_checks++; if (done4 !== 1'b0 || out4 !== 8'(m4)) begin
            n_fail++; $display("FAIL single_after%0d: got out=%h done=%b want %h/0", i, out4, done4, 8'(m4));
         end
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 40; i++) begin
         vin4 = 1'b1;
         fn4 = 3'($urandom_range(0, 7));
         if (fn4 == 3'd6) fn4 = 3'd5;
         data4 = 4'($urandom);
         m4 = model(4, fn4, 16'(data4), m4);
         tick;
         n_checks++; if (out4 !== 8'(m4) || done4 !== 1'b1 || rdy4 !== 1'b1) begin
            n_fail++; $display("FAIL b2b%0d fn=%0d d=%h: got out=%h done=%b rdy=%b want %h/1/1", i, fn4, data4, out4, done4, rdy4, 8'(m4));
         end
      end
      vin4 = 1'b0;
      tick;
      n_checks++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL b2b_tail_done: got %b want 0", done4); end
   endtask

   task automatic test_mul_directed;
      vin4 = 1'b1; fn4 = 3'd4; data4 = 4'h7; tick;
      fn4 = 3'd0; data4 = 4'h8; tick;
      m4 = 64'h0F;
      n_checks++; if (out4 !== 8'h0F) begin n_fail++; $display("FAIL mul_setup: got %h want 0f", out4); end
      fn4 = 3'd6; data4 = 4'hF;
      tick;
      fn4 = 3'd0; data4 = 4'h3;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (busy4 !== 1'b1 || rdy4 !== 1'b0 || out4 !== 8'h0F || done4 !== 1'b0) begin
            n_fail++; $display("FAIL mul_busy%0d: got busy=%b rdy=%b out=%h done=%b want 1/0/0f/0", i, busy4, rdy4, out4, done4);
         end
         tick;
      end
      m4 = model(4, 3'd6, 16'h000F, m4);
      n_checks++; if (out4 !== 8'hE1 || done4 !== 1'b1 || rdy4 !== 1'b1 || busy4 !== 1'b0) begin
         n_fail++; $display("FAIL mul_done: got out=%h done=%b rdy=%b busy=%b want e1/1/1/0", out4, done4, rdy4, busy4);
      end
      tick;
      vin4 = 1'b0;
      m4 = model(4, 3'd0, 16'h0003, m4);
      n_checks++; if (out4 !== 8'(m4) || done4 !== 1'b1) begin
         n_fail++; $display("FAIL mul_held_add: got out=%h done=%b want %h/1", out4, done4, 8'(m4));
      end
      tick;
      n_checks++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL mul_held_tail: got done=%b want 0", done4); end
   endtask

   task automatic test_mul_random;
      int cnt;
      longint unsigned held;
      for (int i = 0; i < 12; i++) begin
         vin4 = 1'b1; fn4 = 3'($urandom_range(0, 5)); data4 = 4'($urandom);
         m4 = model(4, fn4, 16'(data4), m4);
         tick;
         fn4 = 3'd6; data4 = 4'($urandom);
         held = m4;
         m4 = model(4, 3'd6, 16'(data4), m4);
         tick;
         vin4 = 1'b0;
         cnt = 0;
         while (done4 !== 1'b1 && cnt < 20) begin
            n_checks++; if (out4 !== 8'(held) || busy4 !== 1'b1) begin
               n_fail++; $display("FAIL mulr%0d_hold: got out=%h busy=%b want %h/1", i, out4, busy4, 8'(held));
            end
            tick;
            cnt++;
         end
         n_checks++; if (cnt != 4) begin n_fail++; $display("FAIL mulr%0d_latency: got %0d want 4", i, cnt); end
         n_checks++; if (out4 !== 8'(m4) || done4 !== 1'b1) begin
            n_fail++; $display("FAIL mulr%0d_result: got out=%h done=%b want %h/1", i, out4, done4, 8'(m4));
         end
         tick;
         n_checks++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL mulr%0d_single_done: got %b want 0", i, done4); end
      end
   endtask

   task automatic test_reset_mid_mul;
      int cnt;
      vin4 = 1'b1; fn4 = 3'd6; data4 = 4'h5;
      tick;
      vin4 = 1'b0;
      tick;
      n_checks++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b want 1", busy4); end
      rst4 = 1'b1;
      tick;
      rst4 = 1'b0;
      m4 = 0;
      n_checks++; if (out4 !== 8'h00 || rdy4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) begin
         n_fail++; $display("FAIL abort_state: got out=%h rdy=%b busy=%b done=%b want 00/1/0/0", out4, rdy4, busy4, done4);
      end
      for (int i = 0; i < 6; i++) begin
         tick;
         n_checks++; if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++; $display("FAIL abort_quiet%0d: got done=%b busy=%b want 0/0", i, done4, busy4);
         end
      end
      vin4 = 1'b1; fn4 = 3'd6; data4 = 4'h7;
      tick;
      vin4 = 1'b0;
      cnt = 0;
      while (done4 !== 1'b1 && cnt < 20) begin tick; cnt++; end
      n_checks++; if (cnt != 4 || out4 !== 8'h00) begin
         n_fail++; $display("FAIL abort_next_mul: got cycles=%0d out=%h want 4/00", cnt, out4);
      end
   endtask

   task automatic test_width8;
      int cnt;
      longint unsigned held;
      vin8 = 1'b1; fn8 = 3'd0; data8 = 8'hFF;
      tick;
      m8 = 64'h00FF;
      n_checks++; if (out8 !== 16'h00FF) begin n_fail++; $display("FAIL w8_setup: got %h want 00ff", out8); end
      fn8 = 3'd6;
      tick;
      vin8 = 1'b0;
      cnt = 0;
      while (done8 !== 1'b1 && cnt < 30) begin
         n_checks++; if (busy8 !== 1'b1 || out8 !== 16'h00FF) begin
            n_fail++; $display("FAIL w8_busy%0d: got busy=%b out=%h want 1/00ff", cnt, busy8, out8);
         end
         tick;
         cnt++;
      end
      m8 = model(8, 3'd6, 16'h00FF, m8);
      n_checks++; if (cnt != 8 || out8 !== 16'hFE01) begin
         n_fail++; $display("FAIL w8_mul: got cycles=%0d out=%h want 8/fe01", cnt, out8);
      end
      vin8 = 1'b1; fn8 = 3'd3; data8 = 8'hFF;
      tick;
      vin8 = 1'b0;
      m8 = model(8, 3'd3, 16'h00FF, m8);
      n_checks++; if (out8 !== 16'h0000 || done8 !== 1'b1) begin
         n_fail++; $display("FAIL w8_anr: got out=%h done=%b want 0000/1", out8, done8);
      end
      for (int i = 0; i < 20; i++) begin
         vin8 = 1'b1; fn8 = 3'($urandom_range(0, 7)); data8 = 8'($urandom);
         held = m8;
         m8 = model(8, fn8, 16'(data8), m8);
         tick;
         vin8 = 1'b0;
         cnt = 0;
         while (done8 !== 1'b1 && cnt < 30) begin
            n_checks++; if (out8 !== 16'(held)) begin
               n_fail++; $display("FAIL w8r%0d_hold: got %h want %h", i, out8, 16'(held));
            end
            tick;
            cnt++;
         end
         n_checks++; if (out8 !== 16'(m8) || cnt != ((fn8 == 3'd6) ? 8 : 0)) begin
            n_fail++; $display("FAIL w8r%0d fn=%0d d=%h: got out=%h cycles=%0d want %h/%0d", i, fn8, data8, out8, cnt, 16'(m8), (fn8 == 3'd6) ? 8 : 0);
         end
         tick;
      end
   endtask

   initial begin
      test_reset;
      test_single_ops;
      test_back_to_back;
      test_mul_directed;
      test_mul_random;
      test_reset_mid_mul;
      test_width8;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion want completion before time limit");
      $fatal(1);
   end

endmodule
